// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: function codes,
// sequencer states and instruction field positions.
package alu_seq_pkg;

  localparam int NREGS = 8;

  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SUB  = 4'b0001;
  localparam logic [3:0] FUNC_INC  = 4'b0010;
  localparam logic [3:0] FUNC_DEC  = 4'b0011;
  localparam logic [3:0] FUNC_OR   = 4'b0100;
  localparam logic [3:0] FUNC_AND  = 4'b0101;
  localparam logic [3:0] FUNC_XOR  = 4'b0110;
  localparam logic [3:0] FUNC_NAND = 4'b0111;
  localparam logic [3:0] FUNC_NOT  = 4'b1000;
  localparam logic [3:0] FUNC_LDI  = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam int FUNC_MSB = 15;
  localparam int FUNC_LSB = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RA_MSB   = 8;
  localparam int RA_LSB   = 6;
  localparam int RB_MSB   = 5;
  localparam int RB_LSB   = 3;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  // Codes 0000..1000 go through the external ALU.
  function automatic logic is_alu_op(input logic [3:0] f);
    return f <= FUNC_NOT;
  endfunction

endpackage

// File: rtl/regfile8x8.sv
// 8x8 register file: two combinational read ports, one synchronous write port,
// synchronous clear. ALU_SEQ_DBG_EN adds a third (debug) read port.
module regfile8x8
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [2:0] raddr_b,
  output logic [7:0] rdata_b
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [2:0] raddr_dbg,
  output logic [7:0] rdata_dbg
`endif
);

  logic [7:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

`ifdef ALU_SEQ_DBG_EN
  assign rdata_dbg = mem[raddr_dbg];
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer around an external 8-bit combinational ALU.
// Optional debug register read port enabled by defining ALU_SEQ_DBG_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_func,
  input  logic [7:0]  alu_result,
  output logic        z_flag,
  output logic        done,
  output logic        err
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
`endif
);

  state_t     state, state_nxt;
  logic       accept;
  logic       rf_we;
  logic [3:0] func_q;
  logic [2:0] rd_q;
  logic [7:0] imm_q;
  logic [7:0] wb_data;
  logic [7:0] rdata_a, rdata_b;

  logic [3:0] func_in;
  logic [2:0] rd_in, ra_in, rb_in;
  logic [7:0] imm_in;

  assign func_in = instr[FUNC_MSB:FUNC_LSB];
  assign rd_in   = instr[RD_MSB:RD_LSB];
  assign ra_in   = instr[RA_MSB:RA_LSB];
  assign rb_in   = instr[RB_MSB:RB_LSB];
  assign imm_in  = instr[IMM_MSB:IMM_LSB];
  assign accept  = instr_valid && instr_ready;

  regfile8x8 u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (wb_data),
    .raddr_a (ra_in),
    .rdata_a (rdata_a),
    .raddr_b (rb_in),
    .rdata_b (rdata_b)
`ifdef ALU_SEQ_DBG_EN
    ,
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    done        = (state == WB);
    rf_we       = (state == WB) && (is_alu_op(func_q) || func_q == FUNC_LDI);
  end

  // LDI and illegal codes leave the ALU inputs untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_q   <= 4'h0;
      rd_q     <= 3'd0;
      imm_q    <= 8'h00;
      wb_data  <= 8'h00;
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      alu_func <= 4'h0;
      z_flag   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            func_q <= func_in;
            rd_q   <= rd_in;
            imm_q  <= imm_in;
            if (is_alu_op(func_in)) begin
              alu_a    <= rdata_a;
              alu_b    <= rdata_b;
              alu_func <= func_in;
            end
          end
        end
        EXEC: wb_data <= (func_q == FUNC_LDI) ? imm_q : alu_result;
        WB: begin
          if (is_alu_op(func_q))        z_flag <= (wb_data == 8'h00);
          else if (func_q != FUNC_LDI)  err    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached; expected
// values are hand-computed constants.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_func;
  logic        z_flag, done, err;

  int n_total = 0;
  int n_bad   = 0;
  int last_wait;
  logic [7:0]  ex_a, ex_b;
  logic [3:0]  ex_f;
  logic [11:0] rdy_pat, done_pat;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .alu_result  (alu_result),
    .z_flag      (z_flag),
    .done        (done),
    .err         (err)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_func)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h2: alu_result = alu_a + 8'd1;
      4'h3: alu_result = alu_a - 8'd1;
      4'h4: alu_result = alu_a | alu_b;
      4'h5: alu_result = alu_a & alu_b;
      4'h6: alu_result = alu_a ^ alu_b;
      4'h7: alu_result = ~(alu_a & alu_b);
      4'h8: alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] op(input logic [3:0] f, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {f, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'hF, rd, 1'b0, imm};
  endfunction

  // Called at a falling edge with the sequencer idle; returns at the falling
  // edge after writeback, with operands seen during EXEC in ex_a/ex_b/ex_f.
  task automatic run(input logic [15:0] w);
    int n = 0;
    instr_valid = 1'b1;
    instr       = w;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    check("accept", {15'd0, instr_ready}, 16'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    ex_a = alu_a; ex_b = alu_b; ex_f = alu_func;
    check("exec_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    check("wb_done", {15'd0, done}, 16'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {15'd0, instr_ready}, 16'd1);
    check("rst_done",  {15'd0, done},        16'd0);
    check("rst_err",   {15'd0, err},         16'd0);
    check("rst_z",     {15'd0, z_flag},      16'd0);
    check("rst_a",     {8'd0, alu_a},        16'h0000);
    check("rst_b",     {8'd0, alu_b},        16'h0000);
    check("rst_f",     {12'd0, alu_func},    16'h0000);

    // LDI/LDI/SUB giving zero
    run(ldi(3'd1, 8'h05));
    check("ldi_holds_f", {12'd0, ex_f}, 16'h0000);
    run(ldi(3'd2, 8'h05));
    run(op(4'h1, 3'd3, 3'd1, 3'd2));
    check("sub_a", {8'd0, ex_a}, 16'h0005);
    check("sub_b", {8'd0, ex_b}, 16'h0005);
    check("sub_f", {12'd0, ex_f}, 16'h0001);
    check("sub_z", {15'd0, z_flag}, 16'd1);
    run(op(4'h4, 3'd7, 3'd3, 3'd3));
    check("r3_val", {8'd0, ex_a}, 16'h0000);

    // wrap-around add, then LDI leaves z alone
    run(ldi(3'd1, 8'hFF));
    check("ldi_z_keep1", {15'd0, z_flag}, 16'd1);
    run(op(4'h0, 3'd4, 3'd1, 3'd1));
    check("add_a", {8'd0, ex_a}, 16'h00FF);
    check("add_z", {15'd0, z_flag}, 16'd0);
    run(op(4'h4, 3'd7, 3'd4, 3'd4));
    check("r4_val", {8'd0, ex_a}, 16'h00FE);
    run(ldi(3'd2, 8'h00));
    check("ldi_z_keep0", {15'd0, z_flag}, 16'd0);

    // illegal opcode with z=1 beforehand
    run(op(4'h6, 3'd7, 3'd1, 3'd1));
    check("xor_z", {15'd0, z_flag}, 16'd1);
    run(ldi(3'd5, 8'h33));
    check("pre_ill_err", {15'd0, err}, 16'd0);
    run(op(4'hA, 3'd5, 3'd2, 3'd3));
    check("ill_f_hold", {12'd0, ex_f}, 16'h0006);
    check("ill_a_hold", {8'd0, ex_a}, 16'h00FF);
    check("ill_err", {15'd0, err}, 16'd1);
    check("ill_z", {15'd0, z_flag}, 16'd1);
    run(op(4'h4, 3'd7, 3'd5, 3'd5));
    check("r5_val", {8'd0, ex_a}, 16'h0033);
    check("err_sticky", {15'd0, err}, 16'd1);

    // valid held high: four INC r1 accepted, one every 3 cycles
    instr_valid = 1'b1;
    instr       = op(4'h2, 3'd1, 3'd1, 3'd0);
    for (int i = 0; i < 12; i++) begin
      rdy_pat[i]  = instr_ready;
      done_pat[i] = done;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("ready_pattern", {4'd0, rdy_pat},  16'h0249);
    check("done_pattern",  {4'd0, done_pat}, 16'h0924);
    run(op(4'h4, 3'd7, 3'd1, 3'd1));
    check("inc_count", {8'd0, ex_a}, 16'h0003);

    // reset during EXEC of ADD r6
    instr_valid = 1'b1;
    instr       = op(4'h0, 3'd6, 3'd1, 3'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("r6_exec_a", {8'd0, alu_a}, 16'h0003);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done",  {15'd0, done},        16'd0);
    check("abort_ready", {15'd0, instr_ready}, 16'd1);
    check("abort_err",   {15'd0, err},         16'd0);
    check("abort_z",     {15'd0, z_flag},      16'd0);
    check("abort_a",     {8'd0, alu_a},        16'h0000);
    check("abort_b",     {8'd0, alu_b},        16'h0000);
    check("abort_f",     {12'd0, alu_func},    16'h0000);
    run(op(4'h4, 3'd7, 3'd6, 3'd6));
    check("abort_accept_wait", last_wait[15:0], 16'd0);
    check("r6_val", {8'd0, ex_a}, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
